// File: rtl/ex_muldiv.sv
// ex_muldiv -- iterative RV32M multiply/divide unit for the EX stage.
//
// It accepts one M-extension operation at a time from the ID/EX register.
// While the operation runs it holds `stall` high so the front of the pipeline
// freezes. It then presents a registered 32-bit `result` together with a
// one-cycle `done` pulse.
//
// Ports
//   clk      in   1   pipeline clock
//   rst      in   1   asynchronous active-low reset
//   start    in   1   ID/EX holds a valid M-op
//   funct3   in   3   MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   rs1_val  in  32   operand A
//   rs2_val  in  32   operand B
//   flush    in   1   squash: abort the current operation without completing
//   stall    out  1   freeze request (combinational)
//   done     out  1   result valid this cycle (registered)
//   result   out 32   registered result, held until the next completion
//
// Build option
//   MULDIV_FAST_MUL_EN: when defined, every multiply is computed in the start
//   cycle with one 64-bit multiply and completes with latency 1. Divides are
//   unaffected. When undefined, multiplies use the 32-cycle shift-add path and
//   no multiplier is inferred.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [31:0] dvs_q, dvs_d;     // multiplicand (mul) or divisor (div) magnitude
  logic [63:0] acc_q, acc_d;     // mul: {partial hi, multiplier}; div: {rem, quotient}
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  // Final sign fix. Multiplies negate the whole 64-bit product before picking
  // a half so that the high half of a negative product is correct.
  function automatic logic [31:0] finalize(input logic [2:0] op, input logic neg,
                                           input logic [63:0] acc);
    logic [63:0] p;
    logic [31:0] v;
    if (op[2]) begin
      v = op[1] ? acc[63:32] : acc[31:0];
      finalize = neg ? -v : v;
    end else begin
      p = neg ? -acc : acc;
      finalize = (op[1:0] == 2'b00) ? p[31:0] : p[63:32];
    end
  endfunction

  // Start-cycle operand decode
  logic        is_div, a_sgn, b_sgn, s_a, s_b, start_neg;
  logic [31:0] mag_a, mag_b;
  logic        div_zero, div_ovf, special;
  logic [31:0] special_res;

  assign is_div = funct3[2];
  // MUL/MULH/MULHSU treat A as signed; MUL/MULH treat B as signed; DIV/REM both.
  assign a_sgn  = is_div ? ~funct3[0] : (funct3 != 3'b011);
  assign b_sgn  = is_div ? ~funct3[0] : ~funct3[1];
  assign s_a    = a_sgn & rs1_val[31];
  assign s_b    = b_sgn & rs2_val[31];
  assign mag_a  = s_a ? -rs1_val : rs1_val;
  assign mag_b  = s_b ? -rs2_val : rs2_val;
  // The remainder takes the dividend's sign; everything else takes sign(A)^sign(B).
  assign start_neg = (is_div && funct3[1]) ? s_a : (s_a ^ s_b);

  assign div_zero = is_div && (rs2_val == 32'd0);
  assign div_ovf  = is_div && !funct3[0] &&
                    (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  assign fast_prod = {{32{s_a}}, rs1_val} * {{32{s_b}}, rs2_val};
  assign special   = !is_div || div_zero || div_ovf;
`else
  assign special   = div_zero || div_ovf;
`endif

  always_comb begin
    special_res = 32'd0;
    if (div_zero) begin
      special_res = funct3[1] ? rs1_val : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!is_div) begin
      special_res = (funct3[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];
    end
`endif
  end

  // One iteration of shift-add multiply or restoring divide
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;
  logic [63:0] step;

  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);
  assign rem_sh   = {acc_q[63:32], acc_q[31]};
  assign rem_diff = rem_sh - {1'b0, dvs_q};

  always_comb begin
    if (!op_q[2]) begin
      step = {mul_sum, acc_q[31:1]};
    end else if (!rem_diff[32]) begin
      step = {rem_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      step = {rem_sh[31:0], acc_q[30:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    dvs_d    = dvs_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d  = funct3;
          neg_d = start_neg;
          cnt_d = 6'd0;
          if (is_div) begin
            dvs_d = mag_b;
            acc_d = {32'd0, mag_a};
          end else begin
            dvs_d = mag_a;
            acc_d = {32'd0, mag_b};
          end
          if (special) begin
            state_d  = S_DONE;
            result_d = special_res;
            done_d   = 1'b1;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d  = S_DONE;
            result_d = finalize(op_q, neg_q, step);
            done_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        // The finished instruction is still in ID/EX here, so start is ignored.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      neg_q    <= 1'b0;
      dvs_q    <= 32'd0;
      acc_q    <= 64'd0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      dvs_q    <= dvs_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // While reset is asserted the pipeline must not see a stall, even if start is high.
  assign stall  = rst && (((state_q == S_IDLE) && start && !flush) || (state_q == S_CALC));
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .flush   (flush),
    .stall   (stall),
    .done    (done),
    .result  (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics computed with plain 64-bit / int arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    int           ia, ib, q;
    longint       sa, sb, ua, ub;
    logic [63:0]  p;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'd0, a}; ub = {32'd0, b};
    ref_res = 32'd0;
    case (f)
      3'd0: begin p = sa * sb; ref_res = p[31:0];  end
      3'd1: begin p = sa * sb; ref_res = p[63:32]; end
      3'd2: begin p = sa * ub; ref_res = p[63:32]; end
      3'd3: begin p = ua * ub; ref_res = p[63:32]; end
      3'd4: begin
        if (b == 0) ref_res = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_res = 32'h8000_0000;
        else begin q = ia / ib; ref_res = q; end
      end
      3'd5: ref_res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) ref_res = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_res = 32'd0;
        else begin q = ia % ib; ref_res = q; end
      end
      default: ref_res = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f[2]) begin
      if (b == 0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  // Presents an op at cycle 0 and checks stall/done every cycle up to completion.
  // With hold=1, start stays high through DONE and the caller issues the next op.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input string tag);
    int          lat;
    logic [31:0] exp;
    lat = exp_lat(f, a, b);
    exp = ref_res(f, a, b);
    @(posedge clk); #1;
    start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; flush = 1'b0;
    @(negedge clk);
    check({tag, " stall c0"}, 32'(stall), 32'd1);
    check({tag, " done c0"}, 32'(done), 32'd0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k < lat) begin
        check({tag, " stall busy"}, 32'(stall), 32'd1);
        check({tag, " done busy"}, 32'(done), 32'd0);
      end else begin
        check({tag, " stall done"}, 32'(stall), 32'd0);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " result"}, result, exp);
      end
    end
    if (!hold) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check({tag, " done after"}, 32'(done), 32'd0);
      check({tag, " stall after"}, 32'(stall), 32'd0);
      check({tag, " result held"}, result, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pulses;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    rst = 1'b0; start = 1'b1; flush = 1'b0; funct3 = 3'd0;
    rs1_val = 32'd7; rs2_val = 32'd6;
    #2;
    check("reset stall", 32'(stall), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;

    // Directed plan
    run_op(3'd0, 32'd7, 32'd6, 1'b0, "MUL 7x6");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, "MULH");
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "MULHSU");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "MULHU");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, "DIV -7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, "REM -7/2");
    run_op(3'd5, 32'd100, 32'd7, 1'b0, "DIVU 100/7");
    run_op(3'd7, 32'd100, 32'd7, 1'b0, "REMU 100/7");
    run_op(3'd4, 32'd5, 32'd0, 1'b0, "DIV by 0");
    run_op(3'd7, 32'd5, 32'd0, 1'b0, "REMU by 0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "DIV ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "REM ovf");

    // Back-to-back: start held through DONE, next op presented at cycle 34
    run_op(3'd0, 32'd3, 32'd4, 1'b1, "B2B first");
    run_op(3'd5, 32'd100, 32'd7, 1'b0, "B2B second");

    // Flush at cycle 10 of a DIVU; previous result (14) must survive
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd5; rs1_val = 32'd1000; rs2_val = 32'd3;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush stall c10", 32'(stall), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("flush stall c11", 32'(stall), 32'd0);
    check("flush done c11", 32'(done), 32'd0);
    check("flush result kept", result, 32'd14);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("flush no done", 32'(pulses), 32'd0);
    check("flush result later", result, 32'd14);

    // Asynchronous reset mid-CALC
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd0; rs1_val = 32'd9; rs2_val = 32'd9;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst stall", 32'(stall), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst result", result, 32'd0);
    start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("postrst stall", 32'(stall), 32'd0);
    check("postrst done", 32'(done), 32'd0);
    run_op(3'd0, 32'd7, 32'd6, 1'b0, "MUL after rst");

    // Randomized ops, biased toward boundary operands
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'h8000_0000;
        4: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(rf, ra, rb, bit'($urandom_range(0, 1)), "rnd");
    end
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
